// File: rtl/adc4emu_tx_pkg.sv
// Shared definitions for the 4-channel ADC link transmit emulator.
// Holds the lane geometry, the default frame and idle words, the mode
// and phase encodings, and the skew sanitising helper.
package adc4emu_tx_pkg;

    localparam int N_CH        = 4;    // sample channels
    localparam int N_LANES     = 8;    // data lanes, two per channel
    localparam int LANE_BITS   = 6;    // bits per lane per sample period
    localparam int SAMPLE_BITS = 12;   // bits per channel sample
    localparam int HIST_BITS   = 12;   // per-lane serial history used for skew

    localparam logic [LANE_BITS-1:0]   FRAME_DEFAULT     = 6'b111000;
    localparam logic [SAMPLE_BITS-1:0] IDLE_WORD_DEFAULT = 12'h000;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_FIXED  = 2'd2,
        MODE_RSVD   = 2'd3     // behaves as FIXED
    } mode_e;

    // Position of the current bit pair inside the 6-bit lane word.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    // Only 0..5 bit-times of delay exist; larger codes fall back to none.
    function automatic logic [2:0] skew_clamp(input logic [2:0] skew);
        return (skew > 3'd5) ? 3'd0 : skew;
    endfunction

endpackage

// File: rtl/adc4emu_tx_if.sv
// Control/data bundle of the ADC link transmit emulator.
// Signals are named from the emulator's point of view (i_ = into it,
// o_ = out of it).
//   i_en      transmit enable
//   i_mode    0 STREAM, 1 RAMP, 2 FIXED, 3 as FIXED
//   i_fixed   word for FIXED mode
//   i_skew    bit-time delay of all lanes, 0..5 (6,7 mean 0)
//   i_din     STREAM samples, channel c at [12c+11:12c]
//   i_dvalid  i_din valid
//   o_dready  i_din accepted this cycle when i_dvalid is high
//   o_dout    lane k DDR pair at [2k+1:2k], [2k+1] is the earlier bit
//   o_frout   frame lane DDR pair, same order
//   o_fstart  pulse with the first pair of each frame
//   o_under   pulse after a STREAM load without valid data
//   o_scnt    frames sent, wrapping
// master = stimulus side, slave = emulator side.
interface adc4emu_tx_if;

    logic                                                      i_en;
    logic [1:0]                                                i_mode;
    logic [adc4emu_tx_pkg::SAMPLE_BITS-1:0]                    i_fixed;
    logic [2:0]                                                i_skew;
    logic [adc4emu_tx_pkg::N_CH*adc4emu_tx_pkg::SAMPLE_BITS-1:0] i_din;
    logic                                                      i_dvalid;
    logic                                                      o_dready;
    logic [2*adc4emu_tx_pkg::N_LANES-1:0]                      o_dout;
    logic [1:0]                                                o_frout;
    logic                                                      o_fstart;
    logic                                                      o_under;
    logic [15:0]                                               o_scnt;

    modport master (
        output i_en, i_mode, i_fixed, i_skew, i_din, i_dvalid,
        input  o_dready, o_dout, o_frout, o_fstart, o_under, o_scnt
    );

    modport slave (
        input  i_en, i_mode, i_fixed, i_skew, i_din, i_dvalid,
        output o_dready, o_dout, o_frout, o_fstart, o_under, o_scnt
    );

endinterface

// File: rtl/adc4emu_tx_lane_ser.sv
// One serial lane: loads a 6-bit word, presents it MSB first as three
// bit pairs, keeps a history of the serial stream and selects the output
// pair delayed by the active skew.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            0 clears the word, history and output
//   i_load          take i_word (last pair of the previous word is out)
//   i_word          6-bit lane word
//   i_skew          active skew in bit-times, 0..5
//   o_pair          registered pair, [1] earlier bit
module adc4emu_tx_lane_ser
    import adc4emu_tx_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [LANE_BITS-1:0] i_word,
    input  logic [2:0]           i_skew,
    output logic [1:0]           o_pair
);

    logic [LANE_BITS-1:0] r_sh;
    logic [HIST_BITS-1:0] r_hist;
    logic [1:0]           r_pair;
    logic [1:0]           w_cur;
    logic [HIST_BITS+1:0] w_ext;
    logic [3:0]           w_idx;

    // Undelayed pair of this cycle is always the top of the shifter.
    assign w_cur = r_sh[LANE_BITS-1 -: 2];

    // Serial stream with bit 0 = latest bit; delaying by S bit-times
    // means picking bits S+1 (earlier) and S (later).
    assign w_ext = {r_hist, w_cur};
    assign w_idx = {1'b0, i_skew};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh   <= '0;
            r_hist <= '0;
            r_pair <= '0;
        end else if (!i_en) begin
            r_sh   <= '0;
            r_hist <= '0;
            r_pair <= '0;
        end else begin
            r_sh   <= i_load ? i_word : {r_sh[LANE_BITS-3:0], 2'b00};
            r_hist <= {r_hist[HIST_BITS-3:0], w_cur};
            r_pair <= {w_ext[w_idx + 4'd1], w_ext[w_idx]};
        end
    end

    assign o_pair = r_pair;

endmodule

// File: rtl/adc4emu_tx.sv
// Transmit-side emulator of the 4-channel 12-bit ADC link (bytewise,
// two lanes per channel, x1 frame). Produces one DDR bit pair per clock
// on 8 data lanes plus the frame lane; sample rate is clock/3.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             adc4emu_tx_if.slave (enable, mode, fixed word, skew,
//                   stream handshake, lane outputs, frame start,
//                   underrun pulse, frame counter)
// Parameters: FRAME (frame-lane word), IDLE_WORD (FIXED default and
// STREAM underrun word).
// Timing: a word loaded at PH2 in cycle t shows its first pair in t+2
// together with o_fstart and the o_scnt increment; o_under is seen in t+1.
module adc4emu_tx
    import adc4emu_tx_pkg::*;
#(
    parameter logic [LANE_BITS-1:0]   FRAME     = FRAME_DEFAULT,
    parameter logic [SAMPLE_BITS-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
)
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    adc4emu_tx_if.slave  bus
);

    phase_e                 r_ph;
    phase_e                 w_ph_next;
    logic [2:0]             r_skew;
    logic [2:0]             w_skew_act;
    logic [SAMPLE_BITS-1:0] r_ramp;
    logic                   r_loaded;
    logic                   r_fstart;
    logic                   r_under;
    logic [15:0]            r_scnt;
    mode_e                  w_mode;
    logic                   w_load;
    logic                   w_dready;
    logic [2*N_LANES-1:0]   w_dout;
    logic [1:0]             w_frout;

    // ---------------- phase FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ph <= PH0;
        else          r_ph <= w_ph_next;
    end

    always_comb begin
        w_ph_next = PH0;
        if (bus.i_en) begin
            case (r_ph)
                PH0:     w_ph_next = PH1;
                PH1:     w_ph_next = PH2;
                default: w_ph_next = PH0;
            endcase
        end
    end

    assign w_mode   = mode_e'(bus.i_mode);
    assign w_load   = bus.i_en && (r_ph == PH2);
    assign w_dready = w_load && (w_mode == MODE_STREAM);

    // Skew is taken from the input on the first pair of a frame and held
    // for the other two, so all pairs of one frame share one delay.
    assign w_skew_act = (r_ph == PH0) ? skew_clamp(bus.i_skew) : r_skew;

    // ---------------- per-channel source and lanes ----------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SAMPLE_BITS-1:0] w_word;

        always_comb begin
            w_word = bus.i_fixed;
            case (w_mode)
                MODE_STREAM: w_word = bus.i_dvalid ? bus.i_din[gi*SAMPLE_BITS +: SAMPLE_BITS]
                                                   : IDLE_WORD;
                MODE_RAMP:   w_word = r_ramp + SAMPLE_BITS'(gi);
                default:     w_word = bus.i_fixed;
            endcase
        end

        // Lane 2c carries bits [11:6], lane 2c+1 bits [5:0].
        adc4emu_tx_lane_ser u_lane_hi (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (bus.i_en),
            .i_load  (w_load),
            .i_word  (w_word[SAMPLE_BITS-1:LANE_BITS]),
            .i_skew  (w_skew_act),
            .o_pair  (w_dout[4*gi +: 2])
        );

        adc4emu_tx_lane_ser u_lane_lo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (bus.i_en),
            .i_load  (w_load),
            .i_word  (w_word[LANE_BITS-1:0]),
            .i_skew  (w_skew_act),
            .o_pair  (w_dout[4*gi+2 +: 2])
        );
    end

    adc4emu_tx_lane_ser u_lane_frame (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bus.i_en),
        .i_load  (w_load),
        .i_word  (FRAME),
        .i_skew  (w_skew_act),
        .o_pair  (w_frout)
    );

    // ---------------- ramp, flags, frame counter ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skew   <= '0;
            r_ramp   <= '0;
            r_loaded <= 1'b0;
            r_fstart <= 1'b0;
            r_under  <= 1'b0;
            r_scnt   <= '0;
        end else begin
            r_skew   <= w_skew_act;
            r_under  <= w_dready && !bus.i_dvalid;
            r_fstart <= 1'b0;
            if (!bus.i_en)   r_loaded <= 1'b0;
            else if (w_load) r_loaded <= 1'b1;
            if (w_load && (w_mode == MODE_RAMP)) r_ramp <= r_ramp + 1'b1;
            // First pair of a loaded frame is being registered now.
            if (bus.i_en && (r_ph == PH0) && r_loaded) begin
                r_fstart <= 1'b1;
                r_scnt   <= r_scnt + 16'd1;
            end
        end
    end

    assign bus.o_dready = w_dready;
    assign bus.o_dout   = w_dout;
    assign bus.o_frout  = w_frout;
    assign bus.o_fstart = r_fstart;
    assign bus.o_under  = r_under;
    assign bus.o_scnt   = r_scnt;

endmodule

// File: tb/tb_adc4emu_tx.sv
// Randomized bench for adc4emu_tx with a bit-timeline reference model:
// every loaded frame is stored as 6-bit lane words, the serial stream of
// each lane is read back from those words, and each output pair is the
// stream delayed by the frame's skew.
module tb_adc4emu_tx;

    localparam logic [11:0] IDLE = 12'h5A5;
    localparam logic [5:0]  FRM  = 6'b111000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adc4emu_tx_if bus ();

    adc4emu_tx #(.FRAME(FRM), .IDLE_WORD(IDLE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int n_xfer = 0;

    // reference model state
    int          n;            // cycle index since enable/reset (0 = first pair slot of nothing)
    int          s_act;        // skew in force for the current frame
    logic [5:0]  fw [4][9];    // lane words of recent frames, ring by frame index
    logic [11:0] m_ramp;
    logic [15:0] m_scnt;
    logic [15:0] e_dout;
    logic [1:0]  e_frout;
    logic        e_fstart;
    logic        e_under;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial bit i of a lane; frame f occupies bits 6f+6..6f+11, MSB first.
    function automatic logic ser_bit(input int lane, input int i);
        int f;
        if (i < 6) return 1'b0;
        f = i / 6 - 1;
        return fw[f % 4][lane][5 - (i % 6)];
    endfunction

    function automatic int clamp_skew(input logic [2:0] s);
        return (s > 3'd5) ? 0 : int'(s);
    endfunction

    task automatic model_reset();
        n        = 0;
        s_act    = 0;
        m_ramp   = '0;
        m_scnt   = '0;
        e_dout   = '0;
        e_frout  = '0;
        e_fstart = 1'b0;
        e_under  = 1'b0;
    endtask

    // One clock: check what the last edge produced, apply inputs,
    // check DREADY, then predict the next edge.
    task automatic cycle(input logic en, input logic [1:0] mode, input logic [2:0] skew,
                         input logic dv, input logic [47:0] din, input logic [11:0] fixed);
        logic [11:0] w;
        int          f;
        @(negedge clk);
        chk("dout",   32'(bus.o_dout),   32'(e_dout));
        chk("frout",  32'(bus.o_frout),  32'(e_frout));
        chk("fstart", 32'(bus.o_fstart), 32'(e_fstart));
        chk("under",  32'(bus.o_under),  32'(e_under));
        chk("scnt",   32'(bus.o_scnt),   32'(m_scnt));
        bus.i_en     = en;
        bus.i_mode   = mode;
        bus.i_skew   = skew;
        bus.i_dvalid = dv;
        bus.i_din    = din;
        bus.i_fixed  = fixed;
        #1;
        chk("dready", 32'(bus.o_dready), 32'(en && (n % 3 == 2) && (mode == 2'd0)));
        if (!en) begin
            n        = 0;
            e_dout   = '0;
            e_frout  = '0;
            e_fstart = 1'b0;
            e_under  = 1'b0;
        end else begin
            if (n % 3 == 0) s_act = clamp_skew(skew);
            for (int l = 0; l < 8; l++) begin
                e_dout[2*l+1] = ser_bit(l, 2*n - s_act);
                e_dout[2*l]   = ser_bit(l, 2*n + 1 - s_act);
            end
            e_frout  = {ser_bit(8, 2*n - s_act), ser_bit(8, 2*n + 1 - s_act)};
            e_fstart = (n % 3 == 0) && (n >= 3);
            if (e_fstart) m_scnt++;
            e_under = 1'b0;
            if (n % 3 == 2) begin
                f = (n - 2) / 3;
                for (int c = 0; c < 4; c++) begin
                    if (mode == 2'd0)      w = dv ? din[12*c +: 12] : IDLE;
                    else if (mode == 2'd1) w = m_ramp + 12'(c);
                    else                   w = fixed;
                    fw[f % 4][2*c]   = w[11:6];
                    fw[f % 4][2*c+1] = w[5:0];
                end
                fw[f % 4][8] = FRM;
                if (mode == 2'd1) m_ramp++;
                if (mode == 2'd0 && !dv) e_under = 1'b1;
                if (mode == 2'd0 && dv) begin
                    n_xfer++;
                    $display("xfer %0d at %0t: din=%012h", n_xfer, $time, din);
                end
            end
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_dout",   32'(bus.o_dout),   32'd0);
        chk("rst_frout",  32'(bus.o_frout),  32'd0);
        chk("rst_scnt",   32'(bus.o_scnt),   32'd0);
        chk("rst_dready", 32'(bus.o_dready), 32'd0);
        chk("rst_fstart", 32'(bus.o_fstart), 32'd0);
        chk("rst_under",  32'(bus.o_under),  32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [63:0] rnd;
    logic [2:0]  cur_skew;
    logic [1:0]  cur_mode;
    logic        en_r;

    initial begin
        bus.i_en = 1'b1; bus.i_mode = 2'd2; bus.i_skew = 3'd0;
        bus.i_dvalid = 1'b0; bus.i_din = '0; bus.i_fixed = '0;
        model_reset();

        // SKEW=1 from reset: frame lane 01,11,00 repeating
        do_reset();
        repeat (5) cycle(1'b1, 2'd2, 3'd1, 1'b0, 48'd0, 12'h000);
        chk("sk1_fr0", 32'(bus.o_frout), 32'b01);
        cycle(1'b1, 2'd2, 3'd1, 1'b0, 48'd0, 12'h000);
        chk("sk1_fr1", 32'(bus.o_frout), 32'b11);
        cycle(1'b1, 2'd2, 3'd1, 1'b0, 48'd0, 12'h000);
        chk("sk1_fr2", 32'(bus.o_frout), 32'b00);
        cycle(1'b1, 2'd2, 3'd1, 1'b0, 48'd0, 12'h000);
        chk("sk1_fr3", 32'(bus.o_frout), 32'b01);

        // Run streaming, then reset mid-frame at PH=1
        for (int i = 0; i < 20 || (n % 3 != 1); i++) begin
            rnd = {$urandom(), $urandom()};
            cycle(1'b1, 2'd0, 3'd0, 1'b1, rnd[47:0], 12'h000);
        end
        do_reset();
        // STREAM ch0=0xABC after release
        repeat (5) cycle(1'b1, 2'd0, 3'd0, 1'b1, 48'hABC, 12'h000);
        chk("abc_fr0", 32'(bus.o_frout), 32'b11);
        chk("abc_l0p0", 32'(bus.o_dout[1:0]), 32'b10);
        chk("abc_l1p0", 32'(bus.o_dout[3:2]), 32'b11);
        chk("abc_fst", 32'(bus.o_fstart), 32'd1);
        chk("abc_scnt", 32'(bus.o_scnt), 32'd1);
        cycle(1'b1, 2'd0, 3'd0, 1'b1, 48'hABC, 12'h000);
        chk("abc_fr1", 32'(bus.o_frout), 32'b10);
        chk("abc_l0p1", 32'(bus.o_dout[1:0]), 32'b10);
        chk("abc_l1p1", 32'(bus.o_dout[3:2]), 32'b11);
        cycle(1'b1, 2'd0, 3'd0, 1'b1, 48'hABC, 12'h000);
        chk("abc_fr2", 32'(bus.o_frout), 32'b00);
        chk("abc_l0p2", 32'(bus.o_dout[1:0]), 32'b10);
        chk("abc_l1p2", 32'(bus.o_dout[3:2]), 32'b00);

        // Underrun: idle word 0x5A5
        do_reset();
        repeat (4) cycle(1'b1, 2'd0, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("und_pulse", 32'(bus.o_under), 32'd1);
        cycle(1'b1, 2'd0, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("und_l0p0", 32'(bus.o_dout[1:0]), 32'b01);
        chk("und_l1p0", 32'(bus.o_dout[3:2]), 32'b10);
        chk("und_scnt", 32'(bus.o_scnt), 32'd1);
        cycle(1'b1, 2'd0, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("und_l0p1", 32'(bus.o_dout[1:0]), 32'b01);
        chk("und_l1p1", 32'(bus.o_dout[3:2]), 32'b01);
        cycle(1'b1, 2'd0, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("und_l0p2", 32'(bus.o_dout[1:0]), 32'b10);
        chk("und_l1p2", 32'(bus.o_dout[3:2]), 32'b01);

        // SKEW=7 behaves as 0
        do_reset();
        repeat (5) cycle(1'b1, 2'd3, 3'd7, 1'b0, 48'd0, 12'h123);
        chk("sk7_fr0", 32'(bus.o_frout), 32'b11);
        cycle(1'b1, 2'd3, 3'd7, 1'b0, 48'd0, 12'h123);
        chk("sk7_fr1", 32'(bus.o_frout), 32'b10);

        // RAMP: frame 0 ch3=3, frame 1 ch0=1, then run through the 4095 wrap
        do_reset();
        repeat (7) cycle(1'b1, 2'd1, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("rmp_ch3f0", 32'(bus.o_dout[15:14]), 32'b11);
        chk("rmp_ch0f0", 32'(bus.o_dout[3:2]), 32'b00);
        repeat (3) cycle(1'b1, 2'd1, 3'd0, 1'b0, 48'd0, 12'h000);
        chk("rmp_ch0f1", 32'(bus.o_dout[3:2]), 32'b01);
        chk("rmp_ch3f1", 32'(bus.o_dout[15:14]), 32'b00);
        cur_skew = 3'd0;
        for (int i = 0; i < 12300; i++) begin
            if (i % 37 == 0) cur_skew = 3'($urandom_range(0, 7));
            cycle(1'b1, 2'd1, cur_skew, 1'b0, 48'd0, 12'h000);
        end

        // Mixed random: modes, skew sweeps, handshake, enable drops
        cur_mode = 2'd0;
        for (int seg = 0; seg < 80; seg++) begin
            cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) cur_skew = 3'($urandom_range(0, 7));
            for (int k = 0; k < int'($urandom_range(6, 60)); k++) begin
                en_r = ($urandom_range(0, 30) != 0);
                rnd  = {$urandom(), $urandom()};
                cycle(en_r, cur_mode, cur_skew, ($urandom_range(0, 3) != 0),
                      rnd[47:0], 12'($urandom()));
            end
        end
        cycle(1'b1, 2'd0, 3'd0, 1'b1, 48'd0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
